// File: rtl/pipecpu_dbgctl.sv
// pipecpu_dbgctl: run/halt/step clock-enable controller and register-file dump streamer for pipecpu.
// Optional PC breakpoint comparator: define BREAKPOINT_EN to add bp_en/bp_addr.
module pipecpu_dbgctl #(
  parameter bit RESET_RUN = 1'b0,
  parameter int CNT_W     = 16,
  parameter int NREG      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  input  logic [31:0]      pc,
  output logic [4:0]       reg_sel,
  input  logic [31:0]      reg_data,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [4:0]       dump_idx,
  output logic [31:0]      dump_data,
  output logic             cpu_en,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [31:0]      cyc_cnt,
`ifdef BREAKPOINT_EN
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
`endif
  output logic [2:0]       dbg_state
);

  // Both channels are valid/ready: a transfer happens on a rising clk edge where
  // valid && ready; the sender holds payload stable while valid && !ready.
  typedef enum logic [2:0] {
    S_HALT = 3'd0,
    S_RUN  = 3'd1,
    S_STEP = 3'd2,
    S_DSEL = 3'd3,
    S_DOUT = 3'd4
  } state_t;

  localparam logic [1:0] OP_RUN     = 2'b00;
  localparam logic [1:0] OP_HALT    = 2'b01;
  localparam logic [1:0] OP_STEP    = 2'b10;
  localparam logic [1:0] OP_DUMP    = 2'b11;
  localparam logic [1:0] CAUSE_CMD  = 2'b00;
  localparam logic [1:0] CAUSE_STEP = 2'b01;
  localparam logic [1:0] CAUSE_BP   = 2'b10;
  localparam state_t     S_RESET    = RESET_RUN ? S_RUN : S_HALT;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
  logic [4:0]         idx_q, idx_d;
  logic               dump_valid_q, dump_valid_d;
  logic [4:0]         dump_idx_q, dump_idx_d;
  logic [31:0]        dump_data_q, dump_data_d;
  logic [1:0]         cause_q, cause_d;
  logic [31:0]        cyc_cnt_q, cyc_cnt_d;
  logic               bp_hit;

`ifdef BREAKPOINT_EN
  // first_q masks the comparator for one cycle so a resume from the breakpoint PC advances.
  logic first_q, first_d;
  assign first_d = (state_q == S_HALT) && ((state_d == S_RUN) || (state_d == S_STEP));
  assign bp_hit  = bp_en && (pc == bp_addr) && !first_q;

  always_ff @(posedge clk) begin
    if (rst) first_q <= RESET_RUN;
    else     first_q <= first_d;
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc;
  assign bp_hit    = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    step_cnt_d   = step_cnt_q;
    idx_d        = idx_q;
    dump_valid_d = dump_valid_q;
    dump_idx_d   = dump_idx_q;
    dump_data_d  = dump_data_q;
    cause_d      = cause_q;
    cmd_ready    = 1'b0;
    cpu_en       = 1'b0;
    case (state_q)
      S_HALT: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (cmd_op)
            OP_RUN:  state_d = S_RUN;
            OP_STEP: begin
              if (cmd_arg != '0) begin
                state_d    = S_STEP;
                step_cnt_d = cmd_arg;
              end else begin
                cause_d = CAUSE_STEP;
              end
            end
            OP_DUMP: begin
              state_d = S_DSEL;
              idx_d   = '0;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cmd_ready = (cmd_op == OP_HALT);
        cpu_en    = !bp_hit;
        if (cmd_valid && cmd_ready) begin
          state_d = S_HALT;
          cause_d = CAUSE_CMD;
        end else if (bp_hit) begin
          state_d = S_HALT;
          cause_d = CAUSE_BP;
        end
      end
      S_STEP: begin
        cmd_ready = (cmd_op == OP_HALT);
        cpu_en    = !bp_hit && (step_cnt_q != '0);
        if (cpu_en) step_cnt_d = step_cnt_q - 1'b1;
        if (cmd_valid && cmd_ready) begin
          state_d = S_HALT;
          cause_d = CAUSE_CMD;
        end else if (bp_hit) begin
          state_d = S_HALT;
          cause_d = CAUSE_BP;
        end else if (step_cnt_q <= CNT_W'(1)) begin
          state_d = S_HALT;
          cause_d = CAUSE_STEP;
        end
      end
      S_DSEL: begin
        state_d      = S_DOUT;
        dump_valid_d = 1'b1;
        dump_idx_d   = idx_q;
        dump_data_d  = reg_data;
      end
      S_DOUT: begin
        if (dump_ready) begin
          dump_valid_d = 1'b0;
          if (idx_q == 5'(NREG - 1)) begin
            state_d = S_HALT;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_DSEL;
          end
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  assign cyc_cnt_d = cyc_cnt_q + 32'(cpu_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RESET;
      step_cnt_q   <= '0;
      idx_q        <= '0;
      dump_valid_q <= 1'b0;
      dump_idx_q   <= '0;
      dump_data_q  <= '0;
      cause_q      <= CAUSE_CMD;
      cyc_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      step_cnt_q   <= step_cnt_d;
      idx_q        <= idx_d;
      dump_valid_q <= dump_valid_d;
      dump_idx_q   <= dump_idx_d;
      dump_data_q  <= dump_data_d;
      cause_q      <= cause_d;
      cyc_cnt_q    <= cyc_cnt_d;
    end
  end

  assign reg_sel    = idx_q;
  assign dump_valid = dump_valid_q;
  assign dump_idx   = dump_idx_q;
  assign dump_data  = dump_data_q;
  assign halt_cause = cause_q;
  assign cyc_cnt    = cyc_cnt_q;
  assign halted     = (state_q == S_HALT) || (state_q == S_DSEL) || (state_q == S_DOUT);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pipecpu_dbgctl.sv
// Bench for pipecpu_dbgctl: CPU stub (pc advances 4 per enabled cycle, register file array)
// plus per-feature scenario tasks; define BREAKPOINT_EN to include the breakpoint scenario.
module tb_pipecpu_dbgctl;
  localparam int CNT_W = 16;
  localparam int NREG  = 32;
  localparam logic [1:0] OP_RUN  = 2'b00;
  localparam logic [1:0] OP_HALT = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_DUMP = 2'b11;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_arg;
  logic [31:0]      pc;
  logic [4:0]       reg_sel;
  logic [31:0]      reg_data;
  logic             dump_valid;
  logic             dump_ready;
  logic [4:0]       dump_idx;
  logic [31:0]      dump_data;
  logic             cpu_en;
  logic             halted;
  logic [1:0]       halt_cause;
  logic [31:0]      cyc_cnt;
  logic [2:0]       dbg_state;
`ifdef BREAKPOINT_EN
  logic             bp_en;
  logic [31:0]      bp_addr;
`endif

  logic [31:0] regs [NREG];
  logic [31:0] exp_q[$];
  int checks;
  int errors;
  int cyc;

  pipecpu_dbgctl #(.RESET_RUN(1'b0), .CNT_W(CNT_W), .NREG(NREG)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .pc(pc), .reg_sel(reg_sel), .reg_data(reg_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
    .cpu_en(cpu_en), .halted(halted), .halt_cause(halt_cause), .cyc_cnt(cyc_cnt),
`ifdef BREAKPOINT_EN
    .bp_en(bp_en), .bp_addr(bp_addr),
`endif
    .dbg_state(dbg_state)
  );

  // ---- clock / reset / CPU stub ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst)         pc <= 32'd0;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  assign reg_data = regs[reg_sel];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---- drivers ----
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cmd_valid = 1'b0; dump_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns at the negedge right after the accepting edge.
  task automatic send_cmd(input logic [1:0] op, input logic [CNT_W-1:0] arg);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    #1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept op=%0d: cmd_ready=%b after %0d cycles, required 1", op, cmd_ready, n);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    do_reset();
    checks++;
    if (halted !== 1'b1 || cpu_en !== 1'b0 || cyc_cnt !== 32'd0 || halt_cause !== 2'b00) begin
      errors++;
      $display("FAIL reset_ctl: halted=%b cpu_en=%b cyc_cnt=%h cause=%b, required 1 0 0 00", halted, cpu_en, cyc_cnt, halt_cause);
    end
    checks++;
    if (dump_valid !== 1'b0 || reg_sel !== 5'd0 || dump_idx !== 5'd0 || dump_data !== 32'd0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_dump: valid=%b sel=%0d idx=%0d data=%h ready=%b, required 0 0 0 0 1", dump_valid, reg_sel, dump_idx, dump_data, cmd_ready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (cyc_cnt !== 32'd0 || cpu_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: cyc_cnt=%h cpu_en=%b, required 0 0", cyc_cnt, cpu_en);
    end
  endtask

  task automatic test_run_halt();
    logic [31:0] c0;
    int t0, k;
    c0 = cyc_cnt;
    send_cmd(OP_RUN, '0);
    t0 = cyc;
    checks++;
    if (cpu_en !== 1'b1 || halted !== 1'b0 || cyc_cnt !== c0) begin
      errors++;
      $display("FAIL run_start: cpu_en=%b halted=%b cyc_cnt=%h, required 1 0 %h", cpu_en, halted, cyc_cnt, c0);
    end
    k = $urandom_range(4, 30);
    repeat (k) @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_STEP; cmd_arg = 16'd5;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL run_step_refused: cmd_ready=%b, required 0", cmd_ready);
    end
    @(negedge clk);
    cmd_op = OP_DUMP;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL run_dump_refused: cmd_ready=%b, required 0", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (cpu_en !== 1'b1 || halted !== 1'b0) begin
      errors++;
      $display("FAIL run_kept: cpu_en=%b halted=%b, required 1 0", cpu_en, halted);
    end
    send_cmd(OP_HALT, '0);
    checks++;
    if (cpu_en !== 1'b0 || halted !== 1'b1 || halt_cause !== 2'b00) begin
      errors++;
      $display("FAIL run_halt: cpu_en=%b halted=%b cause=%b, required 0 1 00", cpu_en, halted, halt_cause);
    end
    checks++;
    if (cyc_cnt - c0 !== 32'(cyc - t0)) begin
      errors++;
      $display("FAIL run_count: cyc_cnt delta=%0d, required %0d", cyc_cnt - c0, cyc - t0);
    end
  endtask

  task automatic test_step_zero();
    logic [31:0] c0;
    c0 = cyc_cnt;
    send_cmd(OP_STEP, '0);
    checks++;
    if (halted !== 1'b1 || cpu_en !== 1'b0 || halt_cause !== 2'b01) begin
      errors++;
      $display("FAIL step_zero: halted=%b cpu_en=%b cause=%b, required 1 0 01", halted, cpu_en, halt_cause);
    end
    send_cmd(OP_HALT, '0);
    repeat (3) @(negedge clk);
    checks++;
    if (cyc_cnt !== c0 || halt_cause !== 2'b01 || halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_in_halt: cyc_cnt=%h cause=%b halted=%b, required %h 01 1", cyc_cnt, halt_cause, halted, c0);
    end
  endtask

  task automatic test_step();
    logic [31:0] c0, p0;
    int n, t0, w;
    for (int it = 0; it < 8; it++) begin
      n  = $urandom_range(1, 20);
      c0 = cyc_cnt;
      p0 = pc;
      send_cmd(OP_STEP, CNT_W'(n));
      t0 = cyc;
      w  = 0;
      while (halted !== 1'b1 && w < 100) begin
        @(negedge clk); w++;
      end
      checks++;
      if (halted !== 1'b1 || (cyc - t0) != n) begin
        errors++;
        $display("FAIL step_len n=%0d: halted=%b after %0d cycles, required 1 after %0d", n, halted, cyc - t0, n);
      end
      checks++;
      if (cyc_cnt - c0 !== 32'(n) || pc - p0 !== 32'(4 * n)) begin
        errors++;
        $display("FAIL step_count n=%0d: cyc delta=%0d pc delta=%0d, required %0d %0d", n, cyc_cnt - c0, pc - p0, n, 4 * n);
      end
      checks++;
      if (halt_cause !== 2'b01 || cpu_en !== 1'b0) begin
        errors++;
        $display("FAIL step_cause: cause=%b cpu_en=%b, required 01 0", halt_cause, cpu_en);
      end
    end
  endtask

  task automatic test_step_abort();
    logic [31:0] c0;
    int t0;
    c0 = cyc_cnt;
    send_cmd(OP_STEP, 16'd200);
    t0 = cyc;
    repeat ($urandom_range(3, 10)) @(negedge clk);
    send_cmd(OP_HALT, '0);
    checks++;
    if (halted !== 1'b1 || halt_cause !== 2'b00 || cpu_en !== 1'b0) begin
      errors++;
      $display("FAIL step_abort: halted=%b cause=%b cpu_en=%b, required 1 00 0", halted, halt_cause, cpu_en);
    end
    checks++;
    if (cyc_cnt - c0 !== 32'(cyc - t0)) begin
      errors++;
      $display("FAIL step_abort_count: cyc delta=%0d, required %0d", cyc_cnt - c0, cyc - t0);
    end
  endtask

  task automatic test_dump(input bit rand_data);
    int words, n;
    bit stall, gap;
    logic [31:0] s_data;
    logic [4:0]  s_idx;
    exp_q.delete();
    for (int i = 0; i < NREG; i++) begin
      regs[i] = rand_data ? $urandom : 32'h100 + 32'(i);
      exp_q.push_back(regs[i]);
    end
    send_cmd(OP_DUMP, '0);
    words = 0; n = 0; stall = 1'b0; gap = 1'b0; s_data = '0; s_idx = '0;
    while (words < NREG && n < 2000) begin
      if (stall) begin
        checks++;
        if (dump_valid !== 1'b1 || dump_data !== s_data || dump_idx !== s_idx) begin
          errors++;
          $display("FAIL dump_stable: valid=%b idx=%0d data=%h, required 1 %0d %h", dump_valid, dump_idx, dump_data, s_idx, s_data);
        end
      end
      if (gap) begin
        checks++;
        if (dump_valid !== 1'b0) begin
          errors++;
          $display("FAIL dump_gap: valid=%b after handshake, required 0", dump_valid);
        end
      end
      if (halted !== 1'b1 || cpu_en !== 1'b0) begin
        checks++; errors++;
        $display("FAIL dump_halted: halted=%b cpu_en=%b, required 1 0", halted, cpu_en);
      end
      dump_ready = 1'($urandom_range(0, 1));
      stall = (dump_valid === 1'b1) && !dump_ready;
      gap   = (dump_valid === 1'b1) && dump_ready;
      if (gap) begin
        checks++;
        if (dump_idx !== 5'(words)) begin
          errors++;
          $display("FAIL dump_idx: idx=%0d, required %0d", dump_idx, words);
        end
        checks++;
        if (exp_q.size() == 0 || dump_data !== exp_q[0]) begin
          errors++;
          $display("FAIL dump_data word %0d: data=%h, required %h", words, dump_data, exp_q.size() ? exp_q[0] : 32'h0);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        words++;
      end
      s_data = dump_data;
      s_idx  = dump_idx;
      @(negedge clk);
      n++;
    end
    dump_ready = 1'b0;
    checks++;
    if (words != NREG) begin
      errors++;
      $display("FAIL dump_words: got %0d words, required %0d", words, NREG);
    end
    checks++;
    if (halted !== 1'b1 || dump_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL dump_end: halted=%b valid=%b cmd_ready=%b, required 1 0 1", halted, dump_valid, cmd_ready);
    end
  endtask

  task automatic test_reset_mid_dump();
    int n;
    for (int i = 0; i < NREG; i++) regs[i] = 32'h100 + 32'(i);
    send_cmd(OP_DUMP, '0);
    n = 0;
    while (!(dump_valid === 1'b1 && dump_idx === 5'd7) && n < 200) begin
      dump_ready = 1'b1;
      @(negedge clk);
      n++;
    end
    dump_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (dump_valid !== 1'b1 || dump_idx !== 5'd7 || dump_data !== 32'h107) begin
      errors++;
      $display("FAIL mid_dump_word: valid=%b idx=%0d data=%h, required 1 7 00000107", dump_valid, dump_idx, dump_data);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (dump_valid !== 1'b0 || halted !== 1'b1 || cpu_en !== 1'b0 || halt_cause !== 2'b00) begin
      errors++;
      $display("FAIL mid_dump_rst: valid=%b halted=%b cpu_en=%b cause=%b, required 0 1 0 00", dump_valid, halted, cpu_en, halt_cause);
    end
    checks++;
    if (reg_sel !== 5'd0 || dump_idx !== 5'd0 || dump_data !== 32'd0 || cyc_cnt !== 32'd0) begin
      errors++;
      $display("FAIL mid_dump_regs: sel=%0d idx=%0d data=%h cyc=%h, required 0 0 0 0", reg_sel, dump_idx, dump_data, cyc_cnt);
    end
    dump_ready = 1'b1;
    repeat (4) @(negedge clk);
    dump_ready = 1'b0;
    checks++;
    if (dump_valid !== 1'b0 || halted !== 1'b1) begin
      errors++;
      $display("FAIL mid_dump_dropped: valid=%b halted=%b, required 0 1", dump_valid, halted);
    end
  endtask

  task automatic test_cyc_wrap();
    @(negedge clk);
    force dut.cyc_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.cyc_cnt_q;
    checks++;
    if (cyc_cnt !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL wrap_preload: cyc_cnt=%h, required ffffffff", cyc_cnt);
    end
    send_cmd(OP_RUN, '0);
    checks++;
    if (cyc_cnt !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL wrap_hold: cyc_cnt=%h, required ffffffff", cyc_cnt);
    end
    @(negedge clk);
    checks++;
    if (cyc_cnt !== 32'd0) begin
      errors++;
      $display("FAIL wrap_zero: cyc_cnt=%h, required 00000000", cyc_cnt);
    end
    @(negedge clk);
    checks++;
    if (cyc_cnt !== 32'd1) begin
      errors++;
      $display("FAIL wrap_next: cyc_cnt=%h, required 00000001", cyc_cnt);
    end
    send_cmd(OP_HALT, '0);
  endtask

`ifdef BREAKPOINT_EN
  task automatic test_breakpoint();
    int n;
    bp_addr = 32'h20;
    bp_en   = 1'b1;
    do_reset();
    send_cmd(OP_RUN, '0);
    n = 0;
    while (halted !== 1'b1 && n < 50) begin
      @(negedge clk); n++;
    end
    checks++;
    if (halted !== 1'b1 || pc !== 32'h20 || halt_cause !== 2'b10) begin
      errors++;
      $display("FAIL bp_stop: halted=%b pc=%h cause=%b, required 1 00000020 10", halted, pc, halt_cause);
    end
    checks++;
    if (cyc_cnt !== 32'd8) begin
      errors++;
      $display("FAIL bp_count: cyc_cnt=%0d, required 8", cyc_cnt);
    end
    send_cmd(OP_RUN, '0);
    repeat (3) @(negedge clk);
    checks++;
    if (halted !== 1'b0 || pc !== 32'h2C) begin
      errors++;
      $display("FAIL bp_resume: halted=%b pc=%h, required 0 0000002c", halted, pc);
    end
    bp_en = 1'b0;
    send_cmd(OP_HALT, '0);
  endtask
`endif

  // ---- sequence and report ----
  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = '0; dump_ready = 1'b0;
`ifdef BREAKPOINT_EN
    bp_en = 1'b0; bp_addr = 32'h0;
`endif
    for (int i = 0; i < NREG; i++) regs[i] = 32'h0;
    test_reset();
    test_run_halt();
    test_step_zero();
    test_step();
    test_step_abort();
    test_dump(1'b0);
    test_dump(1'b1);
    test_reset_mid_dump();
    test_cyc_wrap();
`ifdef BREAKPOINT_EN
    test_breakpoint();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
